// File: rtl/dtw_core_sched_if.sv
// Core-array and merged-sink bus of the DTW scheduler.
// master = scheduler side, slave = core array / sink FIFO side.
interface dtw_core_sched_if #(
  parameter int N_CORES    = 4,
  parameter int AXIS_WIDTH = 32
);
  localparam int SEL_W = $clog2(N_CORES);

  logic [N_CORES-1:0]            core_rs;
  logic                          core_op_mode;
  logic [N_CORES-1:0]            core_busy;
  logic [N_CORES-1:0]            core_load_done;
  logic [SEL_W-1:0]              src_sel;
  logic                          src_sel_valid;
  logic [N_CORES-1:0]            res_empty;
  logic [N_CORES-1:0]            res_rden;
  logic [N_CORES*AXIS_WIDTH-1:0] res_data;
  logic                          sink_fifo_wren;
  logic                          sink_fifo_full;
  logic [AXIS_WIDTH-1:0]         sink_fifo_data;
  logic                          sink_fifo_last;

  modport master (
    output core_rs, core_op_mode, src_sel, src_sel_valid, res_rden,
           sink_fifo_wren, sink_fifo_data, sink_fifo_last,
    input  core_busy, core_load_done, res_empty, res_data, sink_fifo_full
  );

  modport slave (
    input  core_rs, core_op_mode, src_sel, src_sel_valid, res_rden,
           sink_fifo_wren, sink_fifo_data, sink_fifo_last,
    output core_busy, core_load_done, res_empty, res_data, sink_fifo_full
  );
endinterface

// File: rtl/dtw_core_sched.sv
// Scheduler for N_CORES dtw_core instances: reference broadcast, round-robin query
// dispatch with source routing, and 3-word result draining. DTW_SCHED_PERF_EN adds perf counters.
module dtw_core_sched #(
  parameter int N_CORES    = 4,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op_mode,
  output logic                    busy,
  output logic [31:0]             perf_dispatched,
  output logic [31:0]             perf_drained,
  dtw_core_sched_if.master        bus
);
  localparam int          SEL_W = $clog2(N_CORES);
  localparam int unsigned NC    = N_CORES;
  localparam int unsigned W     = AXIS_WIDTH;
  localparam logic [8:0]  HANDOFF_CYCLES = 9'd256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISPATCH,
    S_ROUTE,
    S_DRAIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load_first_q;
  logic             core_mode_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] grant_q;
  logic [SEL_W-1:0] drain_q;
  logic             seen_rise_q;
  logic [8:0]       route_cnt_q;
  logic [1:0]       word_q;

  logic [SEL_W-1:0] rr_pick;
  logic             rr_found;
  logic [SEL_W-1:0] low_pick;
  logic             any_res;
  logic             grant_busy;
  logic             grant_fire;
  logic             xfer;
  logic             record_done;

  // Next idle core strictly after the last grant, wrapping.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int unsigned k = 1; k <= NC; k++) begin
      idx = (32'(rr_ptr_q) + k) % NC;
      if (!rr_found && !bus.core_busy[idx]) begin
        rr_found = 1'b1;
        rr_pick  = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    any_res  = 1'b0;
    low_pick = '0;
    for (int unsigned k = 0; k < NC; k++) begin
      if (!any_res && !bus.res_empty[k]) begin
        any_res  = 1'b1;
        low_pick = SEL_W'(k);
      end
    end
  end

  assign grant_busy = bus.core_busy[grant_q];

  always_comb begin
    state_d            = state_q;
    bus.core_rs        = '0;
    bus.src_sel        = '0;
    bus.src_sel_valid  = 1'b0;
    bus.res_rden       = '0;
    bus.sink_fifo_wren = 1'b0;
    bus.sink_fifo_data = '0;
    bus.sink_fifo_last = 1'b0;
    grant_fire         = 1'b0;
    xfer               = 1'b0;
    record_done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_mode)                       state_d = S_LOAD;
          else if (&bus.core_load_done)      state_d = S_DISPATCH;
        end
      end
      S_LOAD: begin
        bus.src_sel_valid = 1'b1;
        if (load_first_q)
          bus.core_rs = ~bus.core_busy;
        else if (&bus.core_load_done && !(|bus.core_busy))
          state_d = S_IDLE;
      end
      S_DISPATCH: begin
        if (any_res)
          state_d = S_DRAIN;
        else if (op_mode && !(|bus.core_busy))
          state_d = S_IDLE;
        else if (rr_found) begin
          grant_fire           = 1'b1;
          bus.core_rs[rr_pick] = 1'b1;
          state_d              = S_ROUTE;
        end
      end
      S_ROUTE: begin
        bus.src_sel       = grant_q;
        bus.src_sel_valid = 1'b1;
        // Busy counts as risen in the cycle it is first seen high.
        if ((seen_rise_q || grant_busy) &&
            (!grant_busy || route_cnt_q >= HANDOFF_CYCLES))
          state_d = S_DISPATCH;
      end
      S_DRAIN: begin
        bus.sink_fifo_data = bus.res_data[32'(drain_q)*W +: W];
        if (!bus.sink_fifo_full) begin
          xfer                  = 1'b1;
          bus.res_rden[drain_q] = 1'b1;
          bus.sink_fifo_wren    = 1'b1;
          bus.sink_fifo_last    = (word_q == 2'd2);
          if (word_q == 2'd2) begin
            record_done = 1'b1;
            state_d     = S_DISPATCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_first_q <= 1'b0;
      core_mode_q  <= 1'b0;
      rr_ptr_q     <= SEL_W'(N_CORES - 1);
      grant_q      <= '0;
      drain_q      <= '0;
      seen_rise_q  <= 1'b0;
      route_cnt_q  <= '0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      load_first_q <= (state_q == S_IDLE) && (state_d == S_LOAD);
      // Cores see the job type latched at start, not the live op_mode used to end dispatch.
      if (state_q == S_IDLE && state_d != S_IDLE)
        core_mode_q <= (state_d == S_LOAD);
      if (grant_fire) begin
        rr_ptr_q    <= rr_pick;
        grant_q     <= rr_pick;
        seen_rise_q <= 1'b0;
        route_cnt_q <= 9'd1;
      end else if (state_q == S_ROUTE) begin
        if (grant_busy)
          seen_rise_q <= 1'b1;
        if (route_cnt_q != HANDOFF_CYCLES)
          route_cnt_q <= route_cnt_q + 9'd1;
      end
      if (state_q == S_DISPATCH && state_d == S_DRAIN) begin
        drain_q <= low_pick;
        word_q  <= '0;
      end else if (xfer) begin
        word_q <= record_done ? 2'd0 : word_q + 2'd1;
      end
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign bus.core_op_mode = core_mode_q;

`ifdef DTW_SCHED_PERF_EN
  logic [31:0] dispatched_q;
  logic [31:0] drained_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dispatched_q <= '0;
      drained_q    <= '0;
    end else begin
      if (grant_fire)  dispatched_q <= dispatched_q + 32'd1;
      if (record_done) drained_q    <= drained_q + 32'd1;
    end
  end

  assign perf_dispatched = dispatched_q;
  assign perf_drained    = drained_q;
`else
  assign perf_dispatched = '0;
  assign perf_drained    = '0;
`endif
endmodule

// File: tb/tb_dtw_core_sched.sv
// Scoreboard bench for dtw_core_sched with behavioural core/result-FIFO models.
`timescale 1ns/1ps
module tb_dtw_core_sched;
  localparam int NC = 4;
  localparam int W  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_mode;
  logic        busy;
  logic [31:0] perf_dispatched;
  logic [31:0] perf_drained;

  dtw_core_sched_if #(.N_CORES(NC), .AXIS_WIDTH(W)) bus ();

  dtw_core_sched #(.N_CORES(NC), .AXIS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_mode(op_mode), .busy(busy),
    .perf_dispatched(perf_dispatched), .perf_drained(perf_drained), .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned   core;
    logic [W-1:0]  data;
    logic          last;
  } exp_t;

  exp_t         sb[$];
  int unsigned  exp_grant[$];
  int unsigned  inj_core[$];
  logic [W-1:0] inj_word[$];
  int unsigned  grants_seen   = 0;
  int unsigned  recs_injected = 0;
  int unsigned  last_grant    = 0;

  // Behavioural cores and FWFT result FIFOs
  logic [W-1:0]   fifo [NC][$];
  int unsigned    busy_cnt [NC];
  logic [NC-1:0]  loading  = '0;
  logic [NC-1:0]  busy_v   = '0;
  logic [NC-1:0]  ld_v     = 4'b0111;
  logic [NC-1:0]  rs_s     = '0;
  logic [NC-1:0]  rden_s   = '0;
  logic           mode_s   = 1'b0;

  always @(posedge clk) begin
    logic [NC-1:0]   emp;
    logic [NC*W-1:0] rd;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        fifo[i].delete();
        busy_cnt[i] = 0;
      end
      busy_v  = '0;
      loading = '0;
      inj_core.delete();
      inj_word.delete();
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (rs_s[i]) begin
          compared++;
          if (busy_v[i]) begin
            mismatched++;
            $display("FAIL rs_to_busy_core: core %0d got run-start while busy", i);
          end
          busy_v[i] = 1'b1;
          if (mode_s) begin
            busy_cnt[i] = 10;
            ld_v[i]     = 1'b0;
            loading[i]  = 1'b1;
          end else begin
            busy_cnt[i] = $urandom_range(2, 6);
          end
        end else if (busy_cnt[i] > 0) begin
          busy_cnt[i]--;
          if (busy_cnt[i] == 0) begin
            busy_v[i] = 1'b0;
            if (loading[i]) begin
              ld_v[i]    = 1'b1;
              loading[i] = 1'b0;
            end
          end
        end
        if (rden_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      end
      while (inj_core.size() > 0) fifo[inj_core.pop_front()].push_back(inj_word.pop_front());
    end
    for (int i = 0; i < NC; i++) begin
      emp[i]          = (fifo[i].size() == 0);
      rd[i*W +: W]    = emp[i] ? '0 : fifo[i][0];
    end
    bus.core_busy      <= busy_v;
    bus.core_load_done <= ld_v;
    bus.res_empty      <= emp;
    bus.res_data       <= rd;
  end

  // Monitor: samples at the falling edge, pops the scoreboards
  always @(negedge clk) begin
    rs_s   = bus.core_rs;
    rden_s = bus.res_rden;
    mode_s = bus.core_op_mode;
    if (!rst) begin
      if (bus.core_rs != '0 && !bus.core_op_mode) begin
        grants_seen++;
        if (exp_grant.size() == 0) check("grant_unexpected", bus.core_rs, 0);
        else begin
          last_grant = exp_grant.pop_front();
          check("grant_rs", bus.core_rs, 64'd1 << last_grant);
        end
      end
      if (bus.src_sel_valid && bus.core_op_mode) check("load_src_sel", bus.src_sel, 0);
      if (bus.src_sel_valid && !bus.core_op_mode && bus.core_rs == '0)
        check("route_src_sel", bus.src_sel, last_grant);
      if (bus.sink_fifo_wren) begin
        check("wren_while_full", bus.sink_fifo_full, 0);
        if (sb.size() == 0) check("sink_unexpected_word", bus.sink_fifo_data, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sink_data", bus.sink_fifo_data, e.data);
          check("sink_last", bus.sink_fifo_last, e.last);
          check("rden_core", bus.res_rden, 64'd1 << e.core);
        end
      end else if (bus.sink_fifo_full) begin
        check("rden_during_stall", bus.res_rden, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input int unsigned c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] d);
    inj_core.push_back(c); inj_word.push_back(a);
    inj_core.push_back(c); inj_word.push_back(b);
    inj_core.push_back(c); inj_word.push_back(d);
    sb.push_back('{c, a, 1'b0});
    sb.push_back('{c, b, 1'b0});
    sb.push_back('{c, d, 1'b1});
    recs_injected++;
  endtask

  task automatic refill_grants();
    exp_grant.delete();
    for (int k = 0; k < 400; k++) exp_grant.push_back(k % NC);
  endtask

  task automatic wait_drained(input bit rand_full);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      step();
      bus.sink_fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      n++;
    end
    bus.sink_fifo_full = 1'b0;
    check("drain_complete", sb.size(), 0);
  endtask

  task automatic wait_wren(input string name);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!bus.sink_fifo_wren && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.sink_fifo_wren, 1);
  endtask

  task automatic random_batch();
    for (int c = 0; c < NC; c++) begin
      int unsigned nrec;
      nrec = (c == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int r = 0; r < int'(nrec); r++)
        inject(c, $urandom, $urandom, $urandom);
    end
  endtask

  initial begin
    int unsigned n;
    logic [31:0] exp_disp;
    logic [31:0] exp_drn;
    rst = 1'b1; start = 1'b0; op_mode = 1'b0; bus.sink_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_core_rs", bus.core_rs, 0);
    check("rst_src_sel", bus.src_sel, 0);
    check("rst_src_sel_valid", bus.src_sel_valid, 0);
    check("rst_res_rden", bus.res_rden, 0);
    check("rst_wren", bus.sink_fifo_wren, 0);
    check("rst_last", bus.sink_fifo_last, 0);
    check("rst_data", bus.sink_fifo_data, 0);
    check("rst_perf_dispatched", perf_dispatched, 0);
    check("rst_perf_drained", perf_drained, 0);
    step(); rst = 1'b0;

    // Query start with one core not loaded must be ignored
    step(); start = 1'b1; op_mode = 1'b0;
    step(); start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("not_loaded_busy", busy, 0);
      check("not_loaded_rs", bus.core_rs, 0);
    end

    // Reference load broadcast
    step(); start = 1'b1; op_mode = 1'b1;
    step(); start = 1'b0;
    @(negedge clk);
    check("load_busy", busy, 1);
    check("load_rs_all", bus.core_rs, 4'b1111);
    check("load_src_valid", bus.src_sel_valid, 1);
    @(negedge clk);
    check("load_rs_once", bus.core_rs, 0);
    n = 0;
    while (!(&bus.core_load_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("load_done_seen", &bus.core_load_done, 1);
    check("busy_with_all_done", busy, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);

    // Query dispatch with result draining
    refill_grants();
    step(); start = 1'b1; op_mode = 1'b0;
    step(); start = 1'b0;
    repeat ($urandom_range(10, 30)) step();
    inject(2, 32'd7, 32'h120, 32'h55);
    wait_drained(1'b0);

    repeat ($urandom_range(5, 25)) step();
    random_batch();
    wait_wren("stall_record_started");
    step();
    bus.sink_fifo_full = 1'b1;
    repeat (5) step();
    bus.sink_fifo_full = 1'b0;
    wait_drained(1'b0);

    for (int b = 0; b < 3; b++) begin
      repeat ($urandom_range(5, 30)) step();
      random_batch();
      wait_drained(1'b1);
    end

    step(); op_mode = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    @(negedge clk);
    check("dispatch_exit_idle", busy, 0);
`ifdef DTW_SCHED_PERF_EN
    exp_disp = grants_seen;
    exp_drn  = recs_injected;
`else
    exp_disp = '0;
    exp_drn  = '0;
`endif
    check("perf_dispatched", perf_dispatched, exp_disp);
    check("perf_drained", perf_drained, exp_drn);

    // Reset in the middle of a record
    refill_grants();
    step(); start = 1'b1; op_mode = 1'b0;
    step(); start = 1'b0;
    repeat (8) step();
    inject(1, $urandom, $urandom, $urandom);
    wait_wren("abort_record_started");
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
    sb.delete();
    exp_grant.delete();
    repeat (10) begin
      @(negedge clk);
      check("post_rst_wren", bus.sink_fifo_wren, 0);
      check("post_rst_busy", busy, 0);
    end
    check("post_rst_perf_dispatched", perf_dispatched, 0);
    check("post_rst_perf_drained", perf_drained, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/dtw_core_sched.md
DTW_CORE_SCHED -- requirements
Module: dtw_core_sched

Interface
- REQ-001: Parameter N_CORES, default 4, number of dtw_core instances scheduled (2..8).
- REQ-002: Parameter AXIS_WIDTH, default 32, width of query-id/result words.
- REQ-003: clk  input  1  sole clock; all logic on rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: start  input  1  one-cycle pulse; begins the job selected by op_mode.
- REQ-006: op_mode  input  1  0 = query dispatch, 1 = reference load (broadcast).
- REQ-007: busy  output  1  high whenever state != IDLE.
- REQ-008: core_rs  output  N_CORES  per-core run-start pulse.
- REQ-009: core_op_mode  output  1  op_mode driven to all cores.
- REQ-010: core_busy  input  N_CORES  per-core busy.
- REQ-011: core_load_done  input  N_CORES  per-core reference-loaded flag.
- REQ-012: src_sel  output  clog2(N_CORES)  index of core owning the source stream.
- REQ-013: src_sel_valid  output  1  source stream routed to core src_sel (0 = stream to none).
- REQ-014: res_empty  input  N_CORES  per-core result FIFO empty.
- REQ-015: res_rden  output  N_CORES  per-core result FIFO read enable, first-word-fall-through.
- REQ-016: res_data  input  N_CORES*AXIS_WIDTH  per-core result word, core i at bits [i*W +: W].
- REQ-017: sink_fifo_wren / sink_fifo_full / sink_fifo_data / sink_fifo_last  out/in/out(AXIS_WIDTH)/out  merged result output.
- REQ-018: perf_dispatched, perf_drained  output  32 each  performance counters (see Configuration).

Function
- REQ-019: States IDLE, LOAD, DISPATCH, ROUTE, DRAIN; exactly one active.
- REQ-020: IDLE: start with op_mode=1 -> LOAD; start with op_mode=0 and all core_load_done high -> DISPATCH; otherwise stay IDLE, start ignored.
- REQ-021: LOAD: core_rs all ones for exactly the first cycle; src_sel_valid=1, src_sel=0 (broadcast); exit to IDLE the cycle after core_load_done is all ones and core_busy all zero.
- REQ-022: DISPATCH: if any result FIFO non-empty -> DRAIN (drain has priority); else pick next idle core (core_busy=0) round-robin starting after last granted index; pulse its core_rs one cycle -> ROUTE; if none idle, stay.
- REQ-023: ROUTE: src_sel=granted index, src_sel_valid=1; return to DISPATCH when granted core_busy has risen and then fallen, or earlier when it has risen and 256 cycles have elapsed since grant (source handoff window).
- REQ-024: DRAIN: serve lowest-index non-empty core; transfer exactly 3 words (qid, position, minval) to sink, one per cycle when sink_fifo_full=0; res_rden and sink_fifo_wren asserted in same cycle.
- REQ-025: sink_fifo_last=1 only with the third word of each record; stall (no rden, no wren) while sink_fifo_full=1 with counter held.
- REQ-026: After 3rd word -> DISPATCH; start pulses while busy ignored; leave DISPATCH to IDLE only when start... no: DISPATCH returns to IDLE when op_mode=1 sampled with all cores idle and all result FIFOs empty.
- REQ-027: Round-robin pointer advances only on a grant; wraps N_CORES-1 -> 0.
- REQ-028: core_rs is never asserted to a core whose core_busy=1.

Reset
- REQ-029: On rst: state IDLE; busy, core_rs, src_sel, src_sel_valid, res_rden, sink_fifo_wren, sink_fifo_last, sink_fifo_data = 0; RR pointer = N_CORES-1; perf counters 0.
- REQ-030: rst mid-transfer aborts the record; no partial completion after reset.

Configuration
- REQ-031: Macro DTW_SCHED_PERF_EN defined: perf_dispatched increments per core_rs grant in DISPATCH, perf_drained per completed 3-word record, both wrap at 2^32.
- REQ-032: Macro undefined: both perf outputs constant 0, no counter logic.

Verification
- REQ-033: start, op_mode=1, cores raise load_done after 10 cycles -> core_rs=4'b1111 one cycle, busy drops 1 cycle after all done.
- REQ-034: op_mode=0, all idle -> grants core 0,1,2,3,0 in order; src_sel matches each grant.
- REQ-035: Core 2 result FIFO holds {7, 0x120, 0x55} -> sink receives 7, 0x120, 0x55; last only on 0x55.
- REQ-036: sink_fifo_full held 5 cycles mid-record -> no wren/rden during stall; words intact, order preserved.
- REQ-037: start op_mode=0 with load_done=4'b0111 -> stays IDLE, busy=0.
- REQ-038: With DTW_SCHED_PERF_EN, 6 grants and 2 drains -> perf_dispatched=6, perf_drained=2; without macro both 0.
